// File: rtl/id_ex_stage_pkg.sv
// Shared constants and the ID/EX register layout for the RV32I execute stage.
package id_ex_stage_pkg;

  localparam int XLEN    = 32;
  localparam int RA_W    = 5;
  localparam int ALUFN_W = 4;

  localparam logic [ALUFN_W-1:0] ALU_ADD = 4'b0000;

  localparam logic [1:0] ASEL_RS1  = 2'd0;
  localparam logic [1:0] ASEL_PC   = 2'd1;
  localparam logic [1:0] ASEL_ZERO = 2'd2;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [RA_W-1:0]    rs1;
    logic [RA_W-1:0]    rs2;
    logic [RA_W-1:0]    rd;
    logic [1:0]         asel;
    logic               bsel;
    logic [ALUFN_W-1:0] alufn;
    logic               instr5;
    logic [4:0]         shamt;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               branch;
  } idex_t;

  // A bubble clears everything; rs1/rs2 = x0 keeps forwarding inert.
  function automatic idex_t idex_bubble();
    idex_t b;
    b       = '0;
    b.alufn = ALU_ADD;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one EX source register; EX/MEM beats MEM/WB, x0 never forwarded.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [RA_W-1:0] src,
  input  logic [XLEN-1:0] reg_val,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_regwrite,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_regwrite,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] val,
  output logic [1:0]      sel
);

  // Pick the youngest producer of src
  always_comb begin
    val = reg_val;
    sel = FWD_REG;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src)) begin
      val = exmem_result;
      sel = FWD_EXMEM;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src)) begin
      val = memwb_result;
      sel = FWD_MEMWB;
    end else begin
      val = reg_val;
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use bubble insertion.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RA_W-1:0]    id_rs1,
  input  logic [RA_W-1:0]    id_rs2,
  input  logic [RA_W-1:0]    id_rd,
  input  logic [1:0]         id_asel,
  input  logic               id_bsel,
  input  logic [ALUFN_W-1:0] id_alufn,
  input  logic               id_instr5,
  input  logic [4:0]         id_shamt,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_memtoreg,
  input  logic               id_branch,
  input  logic [RA_W-1:0]    exmem_rd,
  input  logic               exmem_regwrite,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic [RA_W-1:0]    memwb_rd,
  input  logic               memwb_regwrite,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    ex_a,
  output logic [XLEN-1:0]    ex_b,
  output logic [ALUFN_W-1:0] ex_alufn,
  output logic [4:0]         ex_shamt,
  output logic               ex_instr5,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_imm,
  output logic [RA_W-1:0]    ex_rd,
  output logic               ex_valid,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg,
  output logic               ex_branch,
  output logic               ld_use_hazard,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);

  idex_t           idex_r;
  idex_t           capture_s;
  logic            hazard_s;
  logic [XLEN-1:0] rs1_fwd_s;
  logic [XLEN-1:0] rs2_fwd_s;

  // Load in EX whose rd feeds the decoding instruction; a flush makes the stall pointless
  always_comb begin
    hazard_s = 1'b0;
    if (idex_r.valid && idex_r.memread && (idex_r.rd != 5'd0) && id_valid && !flush &&
        ((idex_r.rd == id_rs1) || (idex_r.rd == id_rs2))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Decode slot as it would be latched; controls only survive for a real instruction
  always_comb begin
    capture_s          = '0;
    capture_s.valid    = id_valid;
    capture_s.pc       = id_pc;
    capture_s.rs1_data = id_rs1_data;
    capture_s.rs2_data = id_rs2_data;
    capture_s.imm      = id_imm;
    capture_s.rs1      = id_rs1;
    capture_s.rs2      = id_rs2;
    capture_s.rd       = id_rd;
    capture_s.asel     = id_asel;
    capture_s.bsel     = id_bsel;
    capture_s.alufn    = id_alufn;
    capture_s.instr5   = id_instr5;
    capture_s.shamt    = id_shamt;
    capture_s.regwrite = id_regwrite & id_valid;
    capture_s.memread  = id_memread & id_valid;
    capture_s.memwrite = id_memwrite & id_valid;
    capture_s.memtoreg = id_memtoreg & id_valid;
    capture_s.branch   = id_branch & id_valid;
  end

  // Pipeline register: flush > stall > load-use bubble > load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_r <= idex_bubble();
    end else if (flush) begin
      idex_r <= idex_bubble();
    end else if (stall) begin
      idex_r <= idex_r;
    end else if (hazard_s) begin
      idex_r <= idex_bubble();
    end else begin
      idex_r <= capture_s;
    end
  end

  fwd_mux u_fwd_rs1 (
    .src(idex_r.rs1), .reg_val(idex_r.rs1_data),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
    .val(rs1_fwd_s), .sel(fwd_a)
  );

  fwd_mux u_fwd_rs2 (
    .src(idex_r.rs2), .reg_val(idex_r.rs2_data),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
    .val(rs2_fwd_s), .sel(fwd_b)
  );

  // ALU operand A source
  always_comb begin
    case (idex_r.asel)
      ASEL_RS1:  ex_a = rs1_fwd_s;
      ASEL_PC:   ex_a = idex_r.pc;
      ASEL_ZERO: ex_a = 32'd0;
      default:   ex_a = rs1_fwd_s;
    endcase
  end

  assign ex_b          = idex_r.bsel ? idex_r.imm : rs2_fwd_s;
  assign ex_store_data = rs2_fwd_s;
  assign ex_alufn      = idex_r.alufn;
  assign ex_shamt      = idex_r.shamt;
  assign ex_instr5     = idex_r.instr5;
  assign ex_pc         = idex_r.pc;
  assign ex_imm        = idex_r.imm;
  assign ex_rd         = idex_r.rd;
  assign ex_valid      = idex_r.valid;
  assign ex_regwrite   = idex_r.regwrite;
  assign ex_memread    = idex_r.memread;
  assign ex_memwrite   = idex_r.memwrite;
  assign ex_memtoreg   = idex_r.memtoreg;
  assign ex_branch     = idex_r.branch;
  assign ld_use_hazard = hazard_s;

endmodule
